// File: rtl/fake_netlist_vector_driver.sv
// Stimulus-and-capture stage for a combinational fake netlist.
// Builds pseudo-random input vectors from a 32-bit Galois LFSR, applies each
// one as a registered vector, waits a programmable settle time and folds the
// netlist output into a 16-bit MISR signature plus a saturating ones count.
//
// Start handshake: start_i is a request that is accepted only on a clock edge
// where the FSM is in IDLE; seed_i and num_vec_i are captured on that same
// edge. A start seen in any other state, DONE included, is ignored.
// busy_o is high from the cycle after acceptance until the FSM reaches DONE,
// and done_o is a single-cycle pulse marking the end of the run.
module fake_netlist_vector_driver #(
    parameter int N_IN          = 375,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [31:0]     seed_i,
    input  logic [15:0]     num_vec_i,
    output logic [N_IN-1:0] dut_in_o,
    input  logic            dut_out_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [15:0]     signature_o,
    output logic [15:0]     ones_cnt_o
);

    localparam int NUM_WORDS = (N_IN + 31) / 32;
    localparam int WORD_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int SET_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [31:0]       LFSR_TAPS   = 32'h80200003;
    localparam logic [15:0]       MISR_POLY   = 16'h1021;
    localparam logic [WORD_W-1:0] LAST_WORD   = WORD_W'(NUM_WORDS - 1);
    localparam logic [SET_W-1:0]  LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e            r_state;
    logic [31:0]       r_lfsr;
    logic [WORD_W-1:0] r_word;
    logic [SET_W-1:0]  r_settle;
    logic [15:0]       r_vec_cnt;
    logic [15:0]       r_num_vec;
    logic [N_IN-1:0]   r_shadow;
    logic [N_IN-1:0]   r_dut_in;
    logic [15:0]       r_sig;
    logic [15:0]       r_ones;
    logic              r_busy;
    logic              r_done;

    logic [31:0] w_lfsr_next;
    logic [15:0] w_sig_next;
    logic [15:0] w_ones_next;
    logic [15:0] w_vec_cnt_next;
    logic [31:0] w_seed;

    // Next-value logic for the LFSR, MISR, saturating ones count and vector counter.
    always_comb begin
        w_lfsr_next    = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
        w_sig_next     = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? MISR_POLY : 16'h0)
                         ^ {15'b0, dut_out_i};
        w_ones_next    = (dut_out_i && (r_ones != 16'hFFFF)) ? r_ones + 16'd1 : r_ones;
        w_vec_cnt_next = r_vec_cnt + 16'd1;
        // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
        w_seed         = (seed_i == 32'h0) ? 32'h00000001 : seed_i;
    end

    // Shadow vector: during LOAD, word r_word takes the current LFSR state; bits past N_IN are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shadow <= '0;
        end else if (r_state == S_LOAD) begin
            for (int b = 0; b < N_IN; b++) begin
                if (b[WORD_W+4:5] == r_word) begin
                    r_shadow[b] <= r_lfsr[b[4:0]];
                end
            end
        end
    end

    // Main run-control FSM with registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_lfsr    <= '0;
            r_word    <= '0;
            r_settle  <= '0;
            r_vec_cnt <= '0;
            r_num_vec <= '0;
            r_dut_in  <= '0;
            r_sig     <= '0;
            r_ones    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_lfsr    <= w_seed;
                        r_num_vec <= num_vec_i;
                        r_sig     <= '0;
                        r_ones    <= '0;
                        r_vec_cnt <= '0;
                        r_word    <= '0;
                        if (num_vec_i == 16'd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    r_lfsr <= w_lfsr_next;
                    if (r_word == LAST_WORD) begin
                        r_word  <= '0;
                        r_state <= S_APPLY;
                    end else begin
                        r_word <= r_word + 1'b1;
                    end
                end
                S_APPLY: begin
                    r_dut_in <= r_shadow;
                    r_settle <= '0;
                    r_state  <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle == LAST_SETTLE) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_sig     <= w_sig_next;
                    r_ones    <= w_ones_next;
                    r_vec_cnt <= w_vec_cnt_next;
                    if (w_vec_cnt_next == r_num_vec) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dut_in_o    = r_dut_in;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign signature_o = r_sig;
    assign ones_cnt_o  = r_ones;

endmodule

// File: tb/tb_fake_netlist_vector_driver.sv
// Directed bench for fake_netlist_vector_driver: runs a sequence of
// seeded runs, checks every applied vector, settle stability, latency,
// busy duration, done pulses, signature and ones count.
module tb_fake_netlist_vector_driver;

    localparam int N_IN      = 375;
    localparam int SETTLE    = 2;
    localparam int NUM_WORDS = 12;
    localparam int VEC_CYC   = NUM_WORDS + 2 + SETTLE;

    logic            clk_i     = 1'b0;
    logic            rst_ni    = 1'b0;
    logic            start_i   = 1'b0;
    logic [31:0]     seed_i    = '0;
    logic [15:0]     num_vec_i = '0;
    logic [N_IN-1:0] dut_in_o;
    logic            dut_out_i = 1'b0;
    logic            busy_o;
    logic            done_o;
    logic [15:0]     signature_o;
    logic [15:0]     ones_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    int          done_edge;
    int          busy_cycles;
    int          done_pulses;
    logic [15:0] exp_sig;
    logic [15:0] exp_ones;
    logic [31:0] m_lfsr;

    // Clock
    always #5 clk_i = ~clk_i;

    fake_netlist_vector_driver #(
        .N_IN          (N_IN),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .seed_i      (seed_i),
        .num_vec_i   (num_vec_i),
        .dut_in_o    (dut_in_o),
        .dut_out_i   (dut_out_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .signature_o (signature_o),
        .ones_cnt_o  (ones_cnt_o)
    );

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic b);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {15'b0, b};
    endfunction

    task automatic chk(input string tag, input logic [N_IN-1:0] obs, input logic [N_IN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run: start, follow every edge, check each vector against the LFSR model.
    task automatic run(input logic [31:0] seed, input logic [15:0] nv,
                       input logic [31:0] pat, input bit hold_start, input string tag);
        logic [N_IN-1:0] prev_in;
        logic [N_IN-1:0] applied;
        logic [N_IN-1:0] exp_vec;
        int v;
        int phase;
        prev_in  = dut_in_o;
        applied  = dut_in_o;
        m_lfsr   = (seed == 32'h0) ? 32'h00000001 : seed;
        exp_sig  = '0;
        exp_ones = '0;
        seed_i    = seed;
        num_vec_i = nv;
        start_i   = 1'b1;
        @(posedge clk_i); #1;
        if (!hold_start) start_i = 1'b0;
        seed_i    = 32'hDEADBEEF;
        num_vec_i = 16'h0007;
        done_edge   = -1;
        busy_cycles = busy_o ? 1 : 0;
        done_pulses = 0;
        for (int e = 1; e <= 4000; e++) begin
            @(posedge clk_i); #1;
            if (busy_o) busy_cycles++;
            if (done_o) begin
                done_pulses++;
                if (done_edge < 0) begin
                    done_edge = e;
                    start_i   = 1'b0;
                    chk({tag, " busy_at_done"}, N_IN'(busy_o), '0);
                end
            end
            v     = (e - 1) / VEC_CYC;
            phase = e - v * VEC_CYC;
            if (v < int'(nv) && done_edge < 0) begin
                if (phase == 12) begin
                    chk({tag, " held_in_load"}, dut_in_o, applied);
                end
                if (phase == 13) begin
                    exp_vec = '0;
                    for (int w = 0; w < NUM_WORDS; w++) begin
                        for (int b = 0; b < 32; b++) begin
                            if (w * 32 + b < N_IN) exp_vec[w * 32 + b] = m_lfsr[b];
                        end
                        m_lfsr = lfsr_next(m_lfsr);
                    end
                    chk({tag, " vector"}, dut_in_o, exp_vec);
                    applied   = exp_vec;
                    dut_out_i = pat[v];
                    exp_sig   = misr_next(exp_sig, pat[v]);
                    if (pat[v]) exp_ones = exp_ones + 16'd1;
                end
                if (phase == 14 || phase == 15 || phase == 16) begin
                    chk({tag, " settle_stable"}, dut_in_o, applied);
                end
            end
            if (done_edge >= 0 && e >= done_edge + 3) break;
        end
        dut_out_i = 1'b0;
        if (nv == 16'd0) chk({tag, " dut_in_kept"}, dut_in_o, prev_in);
        chk({tag, " done_edge"}, N_IN'(done_edge), N_IN'(int'(nv) * VEC_CYC + 1));
        chk({tag, " done_pulses"}, N_IN'(done_pulses), N_IN'(1));
        chk({tag, " busy_cycles"}, N_IN'(busy_cycles), N_IN'(int'(nv) * VEC_CYC));
        chk({tag, " signature"}, N_IN'(signature_o), N_IN'(exp_sig));
        chk({tag, " ones_cnt"}, N_IN'(ones_cnt_o), N_IN'(exp_ones));
    endtask

    initial begin
        logic [N_IN-1:0] w_vec;
        int pulses;

        // Reset
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst dut_in", dut_in_o, '0);
        chk("rst signature", N_IN'(signature_o), '0);
        chk("rst ones", N_IN'(ones_cnt_o), '0);
        chk("rst busy", N_IN'(busy_o), '0);
        chk("rst done", N_IN'(done_o), '0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Seed 1, one vector, output tied low
        run(32'h1, 16'd1, 32'h0, 1'b0, "t1");
        w_vec = dut_in_o;
        chk("t1 word0", N_IN'(w_vec[31:0]), N_IN'(32'h00000001));
        chk("t1 word1", N_IN'(w_vec[63:32]), N_IN'(32'h80200003));
        chk("t1 sig", N_IN'(signature_o), N_IN'(16'h0000));

        // Output tied high, three vectors
        run(32'h1, 16'd3, 32'hFFFFFFFF, 1'b0, "t2");
        chk("t2 sig", N_IN'(signature_o), N_IN'(16'h0007));
        chk("t2 ones", N_IN'(ones_cnt_o), N_IN'(16'd3));

        // Seed 0 is promoted to 1
        run(32'h0, 16'd1, 32'h1, 1'b0, "t3");
        w_vec = dut_in_o;
        chk("t3 word0", N_IN'(w_vec[31:0]), N_IN'(32'h00000001));
        chk("t3 word1", N_IN'(w_vec[63:32]), N_IN'(32'h80200003));

        // Mixed output pattern, long enough for the MISR to wrap
        run(32'hC0FFEE01, 16'd20, 32'h000A5F3C, 1'b0, "t4");

        // Zero-vector run: immediate done, cleared results, vector held
        run(32'h5, 16'd0, 32'h0, 1'b0, "t5");
        chk("t5 sig", N_IN'(signature_o), '0);

        // Start held through a whole run
        run(32'h13579BDF, 16'd2, 32'h2, 1'b1, "t6");
        @(posedge clk_i); #1;
        chk("t6 no_restart", N_IN'(busy_o), '0);

        // Reset during LOAD of the second vector
        dut_out_i = 1'b1;
        seed_i    = 32'h7;
        num_vec_i = 16'd3;
        start_i   = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        chk("t7 pre_rst ones", N_IN'(ones_cnt_o), N_IN'(16'd1));
        rst_ni = 1'b0;
        #1;
        chk("t7 rst dut_in", dut_in_o, '0);
        chk("t7 rst signature", N_IN'(signature_o), '0);
        chk("t7 rst ones", N_IN'(ones_cnt_o), '0);
        chk("t7 rst busy", N_IN'(busy_o), '0);
        chk("t7 rst done", N_IN'(done_o), '0);
        dut_out_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk_i); #1;
            if (done_o) pulses++;
        end
        chk("t7 no_done", N_IN'(pulses), '0);
        run(32'h1, 16'd1, 32'h0, 1'b0, "t8");
        w_vec = dut_in_o;
        chk("t8 word0", N_IN'(w_vec[31:0]), N_IN'(32'h00000001));
        chk("t8 word1", N_IN'(w_vec[63:32]), N_IN'(32'h80200003));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fake_netlist_vector_driver.md
Name: fake_netlist_vector_driver

Overview:
- Stimulus-and-capture stage that sits directly upstream of a generated fake ibex netlist: it drives the netlist's 375 primary inputs and consumes its single output.
- It builds pseudo-random input vectors from a 32-bit LFSR and applies each one as a stable, registered vector.
- After a programmable settle time it samples the netlist output, compacting all samples into a 16-bit signature and a count of ones.
- It is used for equivalence and regression runs across netlist variants.

Parameters:
- N_IN, 375, width of the DUT input vector; must be at least 1.
- SETTLE_CYCLES, 2, cycles the vector is held before the output is sampled; must be at least 1.
- NUM_WORDS, ceil(N_IN/32) = 12, derived localparam; the number of LFSR words per vector.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  starts a run; sampled only in IDLE.
- seed_i  in  32  LFSR seed, captured on start.
- num_vec_i  in  16  number of vectors in the run, captured on start.
- dut_in_o  out  N_IN  registered vector driven to the netlist inputs.
- dut_out_i  in  1  netlist output; the netlist is combinational.
- busy_o  out  1  high from the cycle after start is accepted until DONE.
- done_o  out  1  one-cycle pulse at the end of a run.
- signature_o  out  16  MISR result.
- ones_cnt_o  out  16  number of captured samples equal to 1 (saturating).

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - dut_in_o, signature_o, ones_cnt_o, busy_o and done_o all go to 0.
  - LFSR, word counter, settle counter and vector counter all go to 0.
- LFSR:
  - Galois form: next = {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 0).
  - A seed of 0 is replaced by 32'h00000001.
  - The LFSR is not reseeded between vectors of the same run.
- FSM states: IDLE, LOAD, APPLY, SETTLE, CAPTURE, DONE.
- IDLE:
  - On start_i, capture the seed and num_vec_i, and clear the signature, ones count and vector counter.
  - If num_vec_i = 0, go to DONE; otherwise go to LOAD.
- LOAD, NUM_WORDS cycles:
  - In cycle k, write the current LFSR state into shadow bits [32k+31 : 32k], then advance the LFSR.
  - Bits at or above N_IN are discarded; for N_IN = 375, word 11 fills [374:352].
  - dut_in_o does not change during LOAD.
- APPLY, 1 cycle: dut_in_o <= shadow, then go to SETTLE.
- SETTLE: hold for SETTLE_CYCLES cycles; dut_in_o stays stable.
- CAPTURE, 1 cycle:
  - Signature update: sig <= {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {15'b0, dut_out_i}.
  - If dut_out_i = 1, increment ones_cnt, saturating at 16'hFFFF.
  - Increment the vector counter; if it reaches num_vec, go to DONE, otherwise go to LOAD.
- DONE, 1 cycle: done_o = 1 and busy_o = 0, then go to IDLE.
- Output persistence:
  - signature_o, ones_cnt_o and dut_in_o hold their values until the next accepted start.
  - On an accepted start, signature_o and ones_cnt_o clear; dut_in_o is held.
- Latency:
  - Each vector takes NUM_WORDS + 2 + SETTLE_CYCLES cycles (16 with defaults).
  - With start accepted at edge 0, done_o is high in the cycle after edge N*(NUM_WORDS + 2 + SETTLE_CYCLES) + 1.
- start_i outside IDLE is ignored, including in the DONE cycle; it causes no restart and no parameter change.
- Reset asserted mid-run aborts immediately; no done_o pulse is produced.
- ones_cnt_o saturates; the signature wraps naturally.

Test Plan:
- seed = 1, num_vec = 1, dut_out_i tied to 0 → dut_in_o[31:0] = 32'h00000001 and dut_in_o[63:32] = 32'h80200003 from the APPLY edge onward; done_o pulses once after 17 edges; signature = 16'h0000, ones_cnt = 0.
- dut_out_i tied to 1, num_vec = 3 → ones_cnt = 3, signature = 16'h0007, busy_o high for exactly 48 cycles.
- seed = 0 → first vector is identical to the seed = 1 case (word0 = 32'h00000001).
- num_vec = 0 → done_o pulses on the next cycle; signature = 0 and ones_cnt = 0; dut_in_o is unchanged.
- rst_ni pulled low during LOAD of vector 2 → all outputs read 0 asynchronously; no done_o pulse; a fresh start afterwards reproduces the seed = 1 vector.
- start_i held high through an entire run with num_vec = 2 → only one run executes, done_o pulses once, and a new run begins only from IDLE.
- Settle-window stability → a bench assertion checks that dut_in_o is unchanged from APPLY through CAPTURE for every vector.
